// File: rtl/mmio_store_queue.sv
// mmio_store_queue: captures cpu stores to the IO region, encodes them into
// word-aligned byte-lane writes, buffers them in a DEPTH-entry FIFO and
// drains them to a peripheral bus.
//
// Peripheral handshake: the head entry is offered while p_valid=1. It
// transfers on a rising edge where p_valid=1 and p_ready=1. While p_valid=1
// and p_ready=0, p_addr/p_wdata/p_be hold their values. p_valid never depends
// on p_ready.

package mmio_store_queue_pkg;
   // Access data type from the MEM stage; signed/unsigned store identically.
   typedef enum logic [2:0] {
      DT_B  = 3'd0,
      DT_H  = 3'd1,
      DT_W  = 3'd2,
      DT_BU = 3'd4,
      DT_HU = 3'd5
   } mem_dt_e;
endpackage

module mmio_store_queue
   import mmio_store_queue_pkg::*;
#(
   parameter int          DEPTH      = 4,
   parameter logic [31:0] IO_BASE    = 32'h0001_0000,
   parameter logic [31:0] IO_MASK    = 32'hFFFF_0000,
   parameter logic [31:0] STATUS_OFF = 32'h0000_FFFC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              m_addr,
   input  logic [31:0]              m_wd,
   input  logic                     m_we,
   input  mem_dt_e                  dt,
   output logic                     io_sel,
   output logic [31:0]              m_rd,
   output logic                     stall,
   output logic                     p_valid,
   input  logic                     p_ready,
   output logic [31:0]              p_addr,
   output logic [31:0]              p_wdata,
   output logic [3:0]               p_be,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     misalign,
   output logic [7:0]               err_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [31:0] STATUS_ADDR = IO_BASE + STATUS_OFF;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // FIFO storage and control state
   logic [31:0]   r_addr_q [DEPTH];
   logic [31:0]   r_data_q [DEPTH];
   logic [3:0]    r_be_q   [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_misalign;
   logic [7:0]    r_err_cnt;

   // Decode and lane-encode results
   logic          w_io_sel;
   logic          w_is_store;
   logic          w_aligned;
   logic [3:0]    w_be;
   logic [31:0]   w_lane_data;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_bad_store;

   // Region decode; status word writes are not queued.
   always_comb begin
      w_io_sel   = ((m_addr & IO_MASK) == IO_BASE);
      w_is_store = m_we & w_io_sel & (m_addr != STATUS_ADDR);
   end

   // Byte-lane encoding and alignment check by access size.
   always_comb begin
      w_aligned   = 1'b1;
      w_be        = 4'b1111;
      w_lane_data = m_wd;
      case (dt)
         DT_B, DT_BU: begin
            w_be        = 4'b0001 << m_addr[1:0];
            w_lane_data = {4{m_wd[7:0]}};
         end
         DT_H, DT_HU: begin
            w_aligned   = ~m_addr[0];
            w_be        = m_addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{m_wd[15:0]}};
         end
         default: begin
            w_aligned   = (m_addr[1:0] == 2'b00);
            w_be        = 4'b1111;
            w_lane_data = m_wd;
         end
      endcase
   end

   // Queue control: a full queue refuses pushes even when popping this cycle.
   always_comb begin
      w_full      = (r_count == FULL_CNT);
      w_empty     = (r_count == '0);
      w_push      = w_is_store & w_aligned & ~w_full;
      w_pop       = ~w_empty & p_ready;
      w_bad_store = w_is_store & ~w_aligned;
   end

   // Entry storage; contents are don't-care until count covers them.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_q[r_wr_ptr] <= {m_addr[31:2], 2'b00};
         r_data_q[r_wr_ptr] <= w_lane_data;
         r_be_q[r_wr_ptr]   <= w_be;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Misaligned stores are dropped, flagged for one cycle and counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_misalign <= 1'b0;
         r_err_cnt  <= 8'd0;
      end else begin
         r_misalign <= w_bad_store;
         if (w_bad_store && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   // Outputs: head fields are forced to zero when empty so reset clears them
   // immediately without resetting the storage array.
   always_comb begin
      io_sel   = w_io_sel;
      m_rd     = (m_addr == STATUS_ADDR) ? {{(32-CW){1'b0}}, r_count} : 32'd0;
      stall    = w_is_store & w_aligned & w_full;
      p_valid  = ~w_empty;
      p_addr   = w_empty ? 32'd0 : r_addr_q[r_rd_ptr];
      p_wdata  = w_empty ? 32'd0 : r_data_q[r_rd_ptr];
      p_be     = w_empty ? 4'd0  : r_be_q[r_rd_ptr];
      count    = r_count;
      misalign = r_misalign;
      err_cnt  = r_err_cnt;
   end

endmodule

// File: tb/tb_mmio_store_queue.sv
// Testbench for mmio_store_queue: directed stores with hand-computed lane
// encodings; a drain monitor compares each peripheral transfer against the
// expected queue.
module tb_mmio_store_queue;
  import mmio_store_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic        m_we;
  mem_dt_e     dt;
  logic        io_sel;
  logic [31:0] m_rd;
  logic        stall;
  logic        p_valid;
  logic        p_ready;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_be;
  logic [2:0]  count;
  logic        misalign;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // expected entry: {addr, wdata, be}
  logic [67:0] exp_q[$];

  mmio_store_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .dt(dt),
    .io_sel(io_sel), .m_rd(m_rd), .stall(stall), .p_valid(p_valid),
    .p_ready(p_ready), .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be),
    .count(count), .misalign(misalign), .err_cnt(err_cnt)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // drain monitor
  always @(negedge clk) begin
    logic [67:0] e;
    if (rst === 1'b1 && p_valid === 1'b1 && p_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL drain_unexpected: got addr=%h wdata=%h be=%b, required no transfer",
                 p_addr, p_wdata, p_be);
      end else begin
        e = exp_q.pop_front();
        if ({p_addr, p_wdata, p_be} !== e) begin
          n_errors++;
          $display("FAIL drain_entry: got addr=%h wdata=%h be=%b, required addr=%h wdata=%h be=%b",
                   p_addr, p_wdata, p_be, e[67:36], e[35:4], e[3:0]);
        end
      end
    end
  end

  // driver: present a store until it is not stalled, then hold it one edge
  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input mem_dt_e t,
                          input logic queued, input logic [31:0] e_addr,
                          input logic [31:0] e_data, input logic [3:0] e_be);
    int waited;
    m_addr = addr;
    m_wd   = wd;
    dt     = t;
    m_we   = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      waited++;
      if (waited > 40) begin
        check("store_stall_timeout", 32'(stall), 32'd0);
        break;
      end
    end
    if (queued) exp_q.push_back({e_addr, e_data, e_be});
    @(posedge clk);
    #1;
    m_we = 1'b0;
  endtask

  task automatic drain_all();
    int cyc;
    p_ready = 1'b1;
    cyc = 0;
    while (count != 3'd0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    p_ready = 1'b0;
    check("drain_count_zero", 32'(count), 32'd0);
    check("drain_exp_q_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b0; m_addr = '0; m_wd = '0; m_we = 1'b0; dt = DT_W; p_ready = 1'b0;
    #12;
    // reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_p_valid", 32'(p_valid), 32'd0);
    check("rst_p_addr", p_addr, 32'd0);
    check("rst_p_wdata", p_wdata, 32'd0);
    check("rst_p_be", 32'(p_be), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // 1: single word store, drains immediately
    p_ready = 1'b1;
    do_store(32'h0001_0010, 32'hDEAD_BEEF, DT_W, 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'b1111);
    check("t1_p_valid_latency", 32'(p_valid), 32'd1);
    check("t1_p_addr", p_addr, 32'h0001_0010);
    check("t1_p_wdata", p_wdata, 32'hDEAD_BEEF);
    check("t1_p_be", 32'(p_be), 32'hF);
    @(posedge clk); #1;
    check("t1_count_after_pop", 32'(count), 32'd0);
    p_ready = 1'b0;

    // 2: byte and half lane replication, status read
    do_store(32'h0001_0003, 32'hFFFF_FFA5, DT_B, 1'b1, 32'h0001_0000, 32'hA5A5_A5A5, 4'b1000);
    do_store(32'h0001_0006, 32'hFFFF_1234, DT_HU, 1'b1, 32'h0001_0004, 32'h1234_1234, 4'b1100);
    check("t2_count", 32'(count), 32'd2);
    check("t2_head_be_stable", 32'(p_be), 32'h8);
    m_addr = 32'h0001_FFFC; #1;
    check("t2_status_rd", m_rd, 32'd2);
    check("t2_status_io_sel", 32'(io_sel), 32'd1);
    m_addr = 32'h0001_0010; #1;
    check("t2_other_io_rd", m_rd, 32'd0);
    m_addr = 32'h0000_0400; #1;
    check("t2_mem_rd", m_rd, 32'd0);
    drain_all();

    // 3: fill to full, fifth store stalls until a pop frees a slot
    for (int i = 1; i <= 4; i++)
      do_store(32'h0001_0020 + 32'(4*i), 32'h1111_1111 * i, DT_W, 1'b1,
               32'h0001_0020 + 32'(4*i), 32'h1111_1111 * i, 4'b1111);
    m_addr = 32'h0001_0034; m_wd = 32'h5555_5555; dt = DT_W; m_we = 1'b1;
    @(negedge clk);
    check("t3_stall_full", 32'(stall), 32'd1);
    check("t3_count_full", 32'(count), 32'd4);
    @(posedge clk); #1; p_ready = 1'b1;
    @(negedge clk);
    check("t3_stall_during_pop", 32'(stall), 32'd1);
    @(posedge clk); #1; p_ready = 1'b0;
    @(negedge clk);
    check("t3_stall_dropped", 32'(stall), 32'd0);
    check("t3_count_after_pop", 32'(count), 32'd3);
    exp_q.push_back({32'h0001_0034, 32'h5555_5555, 4'b1111});
    @(posedge clk); #1; m_we = 1'b0;
    check("t3_count_refilled", 32'(count), 32'd4);
    drain_all();

    // 4: misaligned stores are dropped and counted
    do_store(32'h0001_0001, 32'h0000_1234, DT_H, 1'b0, 32'd0, 32'd0, 4'd0);
    check("t4_misalign_half", 32'(misalign), 32'd1);
    do_store(32'h0001_0002, 32'hCAFE_F00D, DT_W, 1'b0, 32'd0, 32'd0, 4'd0);
    check("t4_misalign_word", 32'(misalign), 32'd1);
    check("t4_err_cnt_2", 32'(err_cnt), 32'd2);
    check("t4_no_push", 32'(count), 32'd0);
    @(posedge clk); #1;
    check("t4_misalign_pulse_end", 32'(misalign), 32'd0);
    for (int i = 0; i < 258; i++)
      do_store(32'h0001_0003, 32'(i), DT_W, 1'b0, 32'd0, 32'd0, 4'd0);
    check("t4_err_cnt_saturate", 32'(err_cnt), 32'd255);
    do_store(32'h0001_FFFC, 32'h1234_5678, DT_W, 1'b0, 32'd0, 32'd0, 4'd0);
    check("t4_status_write_ignored", 32'(count), 32'd0);
    check("t4_status_write_no_misalign", 32'(misalign), 32'd0);

    // 5: simultaneous push and pop at count=2
    do_store(32'h0001_0040, 32'hA0A0_A0A0, DT_W, 1'b1, 32'h0001_0040, 32'hA0A0_A0A0, 4'b1111);
    do_store(32'h0001_0045, 32'h0000_003C, DT_B, 1'b1, 32'h0001_0044, 32'h3C3C_3C3C, 4'b0010);
    p_ready = 1'b1;
    do_store(32'h0001_0048, 32'h5555_BEEF, DT_H, 1'b1, 32'h0001_0048, 32'hBEEF_BEEF, 4'b0011);
    p_ready = 1'b0;
    check("t5_count_push_pop", 32'(count), 32'd2);
    drain_all();
    m_addr = 32'h0000_0400; m_wd = 32'h1; dt = DT_W; m_we = 1'b1;
    @(negedge clk);
    check("t5_mem_io_sel", 32'(io_sel), 32'd0);
    check("t5_mem_no_stall", 32'(stall), 32'd0);
    @(posedge clk); #1; m_we = 1'b0;
    check("t5_mem_not_queued", 32'(count), 32'd0);

    // 6: asynchronous reset mid-drain
    for (int i = 0; i < 3; i++)
      do_store(32'h0001_0100 + 32'(4*i), 32'h0BAD_0000 + 32'(i), DT_W, 1'b1,
               32'h0001_0100 + 32'(4*i), 32'h0BAD_0000 + 32'(i), 4'b1111);
    check("t6_count_3", 32'(count), 32'd3);
    check("t6_p_valid", 32'(p_valid), 32'd1);
    #2; rst = 1'b0; #1;
    check("t6_async_p_valid", 32'(p_valid), 32'd0);
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_p_addr", p_addr, 32'd0);
    check("t6_async_err_cnt", 32'(err_cnt), 32'd0);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    p_ready = 1'b1;
    do_store(32'h0001_0102, 32'h0000_0077, DT_BU, 1'b1, 32'h0001_0100, 32'h7777_7777, 4'b0100);
    check("t6_post_rst_p_be", 32'(p_be), 32'h4);
    drain_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_store_queue.md
Name: mmio_store_queue

Overview:
Sits directly downstream of the pipelined cpu data port (m_addr, m_wd, m_we_m, dt_m) in parallel with the data memory. It captures stores aimed at the IO region and converts them to byte-lane-enabled, word-aligned writes. It buffers them in a DEPTH-entry FIFO and drains them to a slow peripheral bus over a valid/ready handshake. It stalls the cpu when the queue is full and exposes a queue-level status register.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
IO_BASE, 32'h0001_0000, base of IO region
IO_MASK, 32'hFFFF_0000, address is IO when (m_addr & IO_MASK) == IO_BASE
STATUS_OFF, 32'h0000_FFFC, offset of the read-only status word within the IO region

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
m_addr  in  32  cpu data address (MEM stage)
m_wd  in  32  cpu store data, right-aligned
m_we  in  1  cpu store strobe
dt  in  mem_dt_e  access data type
io_sel  out  1  comb: m_addr lies in the IO region (cpu read-mux select)
m_rd  out  32  comb: IO read data
stall  out  1  comb: store must be held by the cpu
p_valid  out  1  head entry valid
p_ready  in  1  peripheral accepts head
p_addr  out  32  word-aligned address ({addr[31:2],2'b00})
p_wdata  out  32  lane-replicated data
p_be  out  4  byte enables
count  out  $clog2(DEPTH)+1  entries held
misalign  out  1  one-cycle pulse, registered, for a dropped misaligned store
err_cnt  out  8  saturating count of misaligned stores

Behaviour:
- Reset (rst=0, async): FIFO empty, count=0, p_valid=0, p_addr/p_wdata/p_be=0, misalign=0, err_cnt=0. All registered outputs take effect immediately, not at the next edge.
- Status address is IO_BASE + STATUS_OFF.
- is_store = m_we & io_sel & (m_addr != status address). Writes to the status address are ignored.
- Lane encoding; signed and unsigned variants behave identically:
  - BYTE: be = 4'b0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - HALF: addr[0] must be 0; be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wd[15:0]}}.
  - WORD: addr[1:0] must be 0; be = 4'b1111; wdata = wd.
- Misaligned store: not queued and never stalls. misalign=1 on the next cycle; err_cnt increments, saturating at 255.
- stall = is_store & aligned & full. Combinational; a push is never accepted while full, even if a pop occurs in the same cycle. The cpu re-presents the store, and it is accepted the cycle after space appears.
- push = is_store & aligned & !full.
- pop = p_valid & p_ready.
- push and pop in the same cycle: count unchanged, both take effect.
- Latency: a store pushed into an empty queue at edge N drives p_valid=1 with its fields after edge N (registered FIFO head).
- p_valid = (count != 0).
- While p_valid=1 and p_ready=0, p_addr/p_wdata/p_be stay stable.
- Drain order is strict FIFO.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- m_rd:
  - status address: {zero-extended count}.
  - other IO addresses: 0.
  - outside IO region: 0 (memory path owns the read).
- io_sel and m_rd are pure functions of m_addr.
- Reset mid-drain: queued entries are discarded; the peripheral sees p_valid fall asynchronously.

Test Plan:
- Reset, then a WORD store of 32'hDEADBEEF to 32'h0001_0010 with p_ready=1 -> next cycle p_valid=1, p_addr=32'h0001_0010, p_be=4'b1111, p_wdata=32'hDEADBEEF; count returns to 0 after the pop.
- BYTE store 8'hA5 to 32'h0001_0003 and HALF store 16'h1234 to 32'h0001_0006 with p_ready=0 -> entry 1 has be=4'b1000, wdata=32'hA5A5A5A5; entry 2 has be=4'b1100, wdata=32'h12341234; count=2; read of 32'h0001_FFFC returns 2.
- Five WORD stores back-to-back with p_ready=0, DEPTH=4 -> stall=1 on the fifth, count=4. Raise p_ready for one cycle -> fifth store accepted the following cycle, stall drops, count=4, drain order 1..5.
- HALF store to 32'h0001_0001 and WORD store to 32'h0001_0002 -> no push, misalign pulses twice, err_cnt=2. 260 misaligned stores -> err_cnt=255.
- Push and pop in the same cycle at count=2 -> count stays 2 and data order is preserved. Store to 32'h0000_0400 -> io_sel=0 and nothing is queued.
- Assert rst low with count=3 and p_valid=1 -> p_valid and count go to 0 before the next clock edge. After release, a new store drains correctly.
